inv_key_schedule: RTL and testbench
===================================

// Module: inv_key_schedule
// PURPOSE
//   Decryption-side AES-256 key scheduler. Loads a 256-bit cipher key, runs the forward
//   expansion once (one 256-bit step per clock), stores all 15 round keys, then streams
//   them in reverse order (round 14 down to round 0) to the decryption round datapath.
//   Sits between the key input register and the inverse-cipher round pipeline.
// PARAMETERS
//   KEY_W   256  cipher key width; 256 is the only legal value
//   RK_W    128  round key width; 128 is the only legal value
//   NRK     15   number of round keys (Nr+1 for AES-256); fixed
// PORTS
//   clk        in   1    rising-edge clock
//   rst        in   1    asynchronous reset, active-high
//   key_in     in   256  cipher key; key_in[255:224] is word w0
//   key_load   in   1    load strobe; sampled only in IDLE
//   busy       out  1    high in EXPAND and STREAM
//   rk_valid   out  1    rk_out, rk_idx and rk_last hold a valid round key
//   rk_ready   in   1    consumer accepts the round key
//   rk_out     out  128  round key; [127:96] is the lowest-indexed word
//   rk_idx     out  4    round number of rk_out: 14..0
//   rk_last    out  1    high with rk_idx==0
// BEHAVIOUR
//   - Reset (async): state=IDLE. busy, rk_valid and rk_last are 0. rk_out is 0. rk_idx is 0.
//     Reset does not clear the key store; see KEY_ZEROIZE_EN.
//   - States: IDLE -> EXPAND on key_load. EXPAND -> STREAM after 7 steps. STREAM -> IDLE on
//     the handshake of round key 0.
//   - IDLE, key_load=1: at the clock edge, store rk[0]=key_in[255:128] and rk[1]=key_in[127:0].
//     Clear the step counter i to 1. Enter EXPAND.
//   - EXPAND step i (1..7), one step per clock:
//     - temp = SubWord(RotWord(w[8i-1])) ^ {rcon(i),24'h0}; rcon = 01,02,04,08,10,20,40.
//     - Words 0-3 of the new block form the usual xor chain: w[8i] = w[8i-8] ^ temp, and so on.
//     - Words 4-7: w[8i+4] = SubWord(w[8i+3]) ^ w[8i-4], then the xor chain continues.
//     - Write rk[2i] and rk[2i+1]. Step 7 writes only rk[14]; its upper words are discarded.
//   - Latency: rk_valid rises in the 8th cycle after the key_load cycle (7 EXPAND cycles).
//   - STREAM handshake:
//     - Present rk[14] first, with rk_idx=14.
//     - A transfer occurs on a cycle with rk_valid & rk_ready. On the next cycle, present
//       rk_idx-1.
//     - rk_valid stays high and rk_out, rk_idx and rk_last stay stable until accepted.
//     - Back-to-back transfers are allowed: 15 keys in 15 cycles when rk_ready=1.
//   - Transfer of rk_idx==0 (rk_last=1): the next cycle shows rk_valid=0 and busy=0, and the
//     block returns to IDLE. A new key_load is accepted in that IDLE cycle.
//   - key_load while busy: ignored; no effect on state or stored keys.
//   - rk_ready while rk_valid=0: ignored.
//   - Reset mid-EXPAND or mid-STREAM: return immediately to IDLE. The partial sequence is
//     abandoned; a new key_load is needed.
//   - rk_out in IDLE and EXPAND: held at 0 (no stale key on the bus).
// CONFIGURATION
//   KEY_ZEROIZE_EN defined:
//     - Each store entry rk[n] is cleared to 0 in the cycle after it is transferred.
//     - The async reset also clears all 15 entries.
//     - After a full stream, all storage reads 0.
//   KEY_ZEROIZE_EN undefined:
//     - Store entries keep their values until the next key_load overwrites them.
//     - The store has no reset (plain registers); rk_out is still forced to 0 outside STREAM.
// TESTING
//   1. FIPS-197 A.3 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
//      rk_ready=1 -> first transfer rk_idx=14, rk_out=fe4890d1e6188d0b046df344706c631e.
//      Last transfer rk_idx=0, rk_out=603deb1015ca71be2b73aef0857d7781, rk_last=1.
//      Exactly 15 transfers, in consecutive cycles.
//   2. Same key, count from key_load -> rk_valid goes high exactly 8 cycles after key_load.
//      busy drops the cycle after the rk_idx=0 transfer.
//   3. Backpressure: rk_ready toggles 1,0,0,1,... -> rk_out and rk_idx stay stable while
//      rk_ready=0. Sequence 14..0 has no skip and no repeat, and matches test 1.
//   4. Pulse key_load with a different key during EXPAND and during STREAM -> output
//      sequence is unchanged, still test 1's keys.
//   5. Assert rst during STREAM at rk_idx=9 -> rk_valid, busy and rk_out are 0 at once.
//      A following key_load of key 0 -> rk_idx=14 key matches a golden model.
//   6. With KEY_ZEROIZE_EN defined: after a full stream, a backdoor read of rk[0..14] is all 0.
//      Without the macro, rk[14] still equals fe4890d1e6188d0b046df344706c631e.

Source files
------------

// File: rtl/inv_key_schedule.sv
// AES-256 decryption key scheduler: expands a 256-bit key one 8-word step per
// clock into a 15-entry round-key store, then streams rk[14]..rk[0] over a
// valid/ready handshake.
// Optional build macro: KEY_ZEROIZE_EN (clear each entry after it is sent and
// clear the whole store on reset).
module inv_key_schedule #(
  parameter int KEY_W = 256,
  parameter int RK_W  = 128,
  parameter int NRK   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RK_W-1:0]  rk_out,
  output logic [3:0]       rk_idx,
  output logic             rk_last
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] i);
    case (i)
      3'd1:    return 8'h01;
      3'd2:    return 8'h02;
      3'd3:    return 8'h04;
      3'd4:    return 8'h08;
      3'd5:    return 8'h10;
      3'd6:    return 8'h20;
      3'd7:    return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

  state_t           state, state_nxt;
  logic [2:0]       step;
  logic [3:0]       idx;
  logic [KEY_W-1:0] kw;      // most recent 8 words of the expansion
  logic [KEY_W-1:0] kw_nxt;
  logic [RK_W-1:0]  rk [NRK];
  logic [31:0]      temp;
  logic [31:0]      n [8];

  logic load, xfer, exp_done;
  assign load     = (state == IDLE) && key_load;
  assign xfer     = (state == STREAM) && rk_ready;
  assign exp_done = (state == EXPAND) && (step == 3'd7);

  // one full 8-word expansion step from the previous block
  always_comb begin
    temp = subword({kw[23:0], kw[31:24]}) ^ {rcon(step), 24'h0};
    n[0] = kw[255:224] ^ temp;
    n[1] = kw[223:192] ^ n[0];
    n[2] = kw[191:160] ^ n[1];
    n[3] = kw[159:128] ^ n[2];
    n[4] = kw[127:96]  ^ subword(n[3]);
    n[5] = kw[95:64]   ^ n[4];
    n[6] = kw[63:32]   ^ n[5];
    n[7] = kw[31:0]    ^ n[6];
    kw_nxt = {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_load) state_nxt = EXPAND;
      EXPAND:  if (exp_done) state_nxt = STREAM;
      STREAM:  if (xfer && idx == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs; the key bus is forced to zero outside STREAM
  always_comb begin
    busy     = (state != IDLE);
    rk_valid = (state == STREAM);
    rk_last  = rk_valid && (idx == 4'd0);
    rk_idx   = idx;
    rk_out   = rk_valid ? rk[idx] : '0;
  end

  // step counter, expansion working block and stream index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= 3'd0;
      idx  <= 4'd0;
      kw   <= '0;
    end else if (load) begin
      step <= 3'd1;
      idx  <= 4'd0;
      kw   <= key_in;
    end else if (state == EXPAND) begin
      step <= step + 3'd1;
      kw   <= kw_nxt;
      if (exp_done) idx <= 4'd14;
    end else if (xfer && idx != 4'd0) begin
      idx <= idx - 4'd1;
    end
  end

`ifdef KEY_ZEROIZE_EN
  // round-key store, cleared on reset and entry-by-entry as keys are sent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NRK; k++) rk[k] <= '0;
    end else if (load) begin
      rk[0] <= key_in[255:128];
      rk[1] <= key_in[127:0];
    end else if (state == EXPAND) begin
      rk[{step, 1'b0}] <= kw_nxt[255:128];
      if (step != 3'd7) rk[{step, 1'b1}] <= kw_nxt[127:0];
    end else if (xfer) begin
      rk[idx] <= '0;
    end
  end
`else
  // round-key store, plain registers held until the next load
  always_ff @(posedge clk) begin
    if (load) begin
      rk[0] <= key_in[255:128];
      rk[1] <= key_in[127:0];
    end else if (state == EXPAND) begin
      rk[{step, 1'b0}] <= kw_nxt[255:128];
      if (step != 3'd7) rk[{step, 1'b1}] <= kw_nxt[127:0];
    end
  end
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Bench for inv_key_schedule: table of key/backpressure vectors checked against
// FIPS-197 constants and a word-serial expansion model, plus reset and
// storage corner sequences.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst, key_load, rk_ready, busy, rk_valid, rk_last;
  logic [255:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  inv_key_schedule dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_last(rk_last));

  always #5 clk = ~clk;

  localparam logic [2047:0] SB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] KA3  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KC3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R14A = 128'hfe4890d1e6188d0b046df344706c631e;

  int checks = 0;
  int errors = 0;
  logic [127:0] gk [15];

  typedef struct {
    logic [255:0] key;
    logic [3:0]   pat;      // rk_ready pattern, bit c%4 in stream cycle c
    logic         disturb;  // pulse key_load during EXPAND and STREAM
    logic         chk14;    // compare first key against exp14
    logic [127:0] exp14;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = SB[8*(255 - int'(w[8*b +: 8])) +: 8];
    return r;
  endfunction

  // textbook word-at-a-time AES-256 expansion
  task automatic gold(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = sw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) gk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_and_expand(input logic [255:0] k, input logic disturb);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1 key_load = 1'b0;
    rk_ready = 1'b1;  // must be ignored while rk_valid=0
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("exp_valid", rk_valid, 0);
      chk("exp_busy", busy, 1);
      chk("exp_out", rk_out, 0);
      if (disturb && c == 3) begin key_in = ~k; key_load = 1'b1; end
      else key_load = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   eidx, cyc;
    logic done, rdy;
    gold(v.key);
    load_and_expand(v.key, v.disturb);
    eidx = 14; done = 1'b0; cyc = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      cyc++;
      chk("st_valid", rk_valid, 1);
      chk("st_busy", busy, 1);
      chk("st_idx", rk_idx, eidx);
      chk("st_out", rk_out, gk[eidx]);
      chk("st_last", rk_last, eidx == 0);
      if (eidx == 14 && v.chk14) chk("rk14_const", rk_out, v.exp14);
      if (eidx == 0) chk("rk0_key", rk_out, v.key[255:128]);
      if (v.disturb && c == 5) begin key_in = ~v.key; key_load = 1'b1; end
      else key_load = 1'b0;
      rdy = v.pat[c % 4];
      rk_ready = rdy;
      if (rdy) begin
        if (eidx == 0) done = 1'b1;
        else eidx--;
      end
    end
    if (!done) chk("stream_timeout", 0, 1);
    if (v.pat == 4'hf) chk("stream_cycles", cyc, 15);
    @(negedge clk);
    rk_ready = 1'b0;
    key_load = 1'b0;
    chk("end_valid", rk_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_out", rk_out, 0);
    chk("end_last", rk_last, 0);
  endtask

  initial begin
    int   guard;
    logic hit;
    vt[0] = '{key: KA3, pat: 4'b1111, disturb: 1'b0, chk14: 1'b1, exp14: R14A};
    vt[1] = '{key: KA3, pat: 4'b1001, disturb: 1'b0, chk14: 1'b1, exp14: R14A};
    vt[2] = '{key: KA3, pat: 4'b1111, disturb: 1'b1, chk14: 1'b1, exp14: R14A};
    vt[3] = '{key: '0,  pat: 4'b1111, disturb: 1'b0, chk14: 1'b0, exp14: '0};
    vt[4] = '{key: '1,  pat: 4'b0101, disturb: 1'b0, chk14: 1'b0, exp14: '0};
    vt[5] = '{key: KC3, pat: 4'b0011, disturb: 1'b1, chk14: 1'b0, exp14: '0};

    // the model itself must reproduce the published A.3 schedule ends
    gold(KA3);
    chk("model_rk14", gk[14], R14A);
    chk("model_rk0", gk[0], 128'h603deb1015ca71be2b73aef0857d7781);

    rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rk_valid, 0);
    chk("rst_last", rk_last, 0);
    chk("rst_out", rk_out, 0);
    chk("rst_idx", rk_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vt[v]);

    // reset while streaming, at rk_idx=9
    gold(KA3);
    load_and_expand(KA3, 1'b0);
    rk_ready = 1'b1;
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 40) begin
      @(negedge clk);
      guard++;
      if (rk_idx == 4'd9 && rk_valid) hit = 1'b1;
    end
    if (!hit) chk("rst_mid_timeout", 0, 1);
    rst = 1'b1;
    rk_ready = 1'b0;
    #1;
    chk("mid_rst_valid", rk_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", rk_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec('{key: '0, pat: 4'b1111, disturb: 1'b0, chk14: 1'b0, exp14: '0});

    // final A.3 stream, then inspect the store directly
    run_vec(vt[0]);
`ifdef KEY_ZEROIZE_EN
    for (int r = 0; r < 15; r++) chk("zeroized", dut.rk[r], 0);
`else
    chk("store_rk14", dut.rk[14], R14A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
